jpeg_sof_parser: RTL and testbench

Parametrised SOF0/SOF1 frame-header parser. It consumes the marker segment payload byte by byte, starting at the Lf high byte that follows FFC0/FFC1. It captures up to MAX_COMP component descriptors, validates the header, and derives maximum sampling factors, chroma format and MCU grid size. It sits between the marker/byte-stream front end and the MCU scheduler/IDCT control, and supports grayscale, 4:4:4, 4:2:2 and 4:2:0 with runtime error reporting.

---
 rtl/jpeg_sof_parser.sv | 264 ++++++++++++++++++++++++++
 tb/tb_jpeg_sof_parser.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_sof_parser.sv
// SOF0/SOF1 frame-header parser: consumes the segment payload from the Lf high byte,
// captures component descriptors, validates the header and derives chroma format and MCU grid.
module jpeg_sof_parser #(
    parameter int MAX_COMP = 4,
    parameter int DIM_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic [5:0]            err,
    output logic [DIM_W-1:0]      width,
    output logic [DIM_W-1:0]      height,
    output logic [2:0]            ncomp,
    output logic [8*MAX_COMP-1:0] comp_id,
    output logic [3*MAX_COMP-1:0] comp_h,
    output logic [3*MAX_COMP-1:0] comp_v,
    output logic [2*MAX_COMP-1:0] comp_tq,
    output logic [2:0]            hmax,
    output logic [2:0]            vmax,
    output logic [1:0]            fmt,
    output logic [DIM_W-1:0]      mcu_cols,
    output logic [DIM_W-1:0]      mcu_rows
);

    typedef enum logic [3:0] {
        IDLE, LEN_H, LEN_L, PREC, Y_H, Y_L, X_H, X_L, NF,
        C_ID, C_HV, C_TQ, SKIP, CALC, DONE
    } state_t;

    localparam logic [DIM_W+2:0] ONE = 1;

    state_t          state;
    logic [15:0]     lf;
    logic [15:0]     rem;
    logic [7:0]      nf;
    logic [7:0]      dim_hi;
    logic [2:0]      k;

    logic            accept;
    logic [15:0]     lf_full;
    logic [15:0]     rem_dec;
    logic [15:0]     lf_expect;
    logic            nf_bad;
    logic            len_bad;
    logic            hv_bad;

    function automatic logic sf_bad(input logic [3:0] f);
        return (f == 4'd0) || (f == 4'd3) || (f > 4'd4);
    endfunction

    // Block-size shift: 8 pixels per block times the max sampling factor (1, 2 or 4).
    function automatic logic [2:0] sh_of(input logic [2:0] m);
        case (m)
            3'd2:    return 3'd4;
            3'd4:    return 3'd5;
            default: return 3'd3;
        endcase
    endfunction

    always_comb begin
        in_ready = state inside {LEN_H, LEN_L, PREC, Y_H, Y_L, X_H, X_L, NF,
                                 C_ID, C_HV, C_TQ, SKIP};
    end

    assign accept    = in_valid & in_ready;
    assign lf_full   = {lf[15:8], in_data};
    assign rem_dec   = rem - 16'd1;
    assign lf_expect = 16'd8 + 16'd3 * {8'd0, in_data};
    assign nf_bad    = (in_data == 8'd0) || (in_data > 8'(MAX_COMP));
    assign len_bad   = (lf != lf_expect);
    assign hv_bad    = sf_bad(in_data[7:4]) || sf_bad(in_data[3:0]);

    // Per-slot "H=V=1" flags, zero-padded so chroma slots 1 and 2 exist for any MAX_COMP.
    logic [MAX_COMP-1:0] slot_unit;
    logic [3:0]          slot_unit_pad;

    generate
        for (genvar gi = 0; gi < MAX_COMP; gi++) begin : g_slot
            assign slot_unit[gi] = (comp_h[3*gi +: 3] == 3'd1) && (comp_v[3*gi +: 3] == 3'd1);
        end
    endgenerate

    assign slot_unit_pad = 4'(slot_unit);

    logic            parsed_ok;
    logic            mcu_ok;
    logic            zero_dim;
    logic            fmt_bad;
    logic [1:0]      fmt_calc;
    logic [5:0]      err_calc;
    logic [DIM_W+2:0] cols_wide;
    logic [DIM_W+2:0] rows_wide;

    always_comb begin
        fmt_calc  = 2'd0;
        fmt_bad   = 1'b0;
        parsed_ok = (err[1:0] == 2'b00);
        mcu_ok    = parsed_ok && !err[3];
        zero_dim  = (width == '0) || (height == '0);
        if (nf == 8'd1) begin
            fmt_calc = 2'd0;
        end else if (nf == 8'd3 && slot_unit_pad[1] && slot_unit_pad[2]) begin
            case ({comp_h[2:0], comp_v[2:0]})
                6'o11:   fmt_calc = 2'd1;
                6'o21:   fmt_calc = 2'd2;
                6'o22:   fmt_calc = 2'd3;
                default: fmt_bad  = 1'b1;
            endcase
        end else begin
            fmt_bad = 1'b1;
        end
        err_calc  = err | {zero_dim, 1'b0, parsed_ok & fmt_bad, 3'b000};
        cols_wide = ({3'b000, width}  + (ONE << sh_of(hmax)) - ONE) >> sh_of(hmax);
        rows_wide = ({3'b000, height} + (ONE << sh_of(vmax)) - ONE) >> sh_of(vmax);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= '0;
            width    <= '0;
            height   <= '0;
            ncomp    <= '0;
            comp_id  <= '0;
            comp_h   <= '0;
            comp_v   <= '0;
            comp_tq  <= '0;
            hmax     <= '0;
            vmax     <= '0;
            fmt      <= '0;
            mcu_cols <= '0;
            mcu_rows <= '0;
            lf       <= '0;
            rem      <= '0;
            nf       <= '0;
            dim_hi   <= '0;
            k        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        state    <= LEN_H;
                        busy     <= 1'b1;
                        err      <= '0;
                        width    <= '0;
                        height   <= '0;
                        ncomp    <= '0;
                        comp_id  <= '0;
                        comp_h   <= '0;
                        comp_v   <= '0;
                        comp_tq  <= '0;
                        hmax     <= '0;
                        vmax     <= '0;
                        fmt      <= '0;
                        mcu_cols <= '0;
                        mcu_rows <= '0;
                        k        <= '0;
                    end
                end
                LEN_H: if (accept) begin
                    lf[15:8] <= in_data;
                    state    <= LEN_L;
                end
                LEN_L: if (accept) begin
                    lf  <= lf_full;
                    rem <= lf_full - 16'd2;
                    if (lf_full < 16'd8) begin
                        err[0] <= 1'b1;
                        state  <= CALC;
                    end else begin
                        state  <= PREC;
                    end
                end
                PREC: if (accept) begin
                    rem <= rem_dec;
                    if (in_data != 8'd8) err[2] <= 1'b1;
                    state <= Y_H;
                end
                Y_H: if (accept) begin
                    rem    <= rem_dec;
                    dim_hi <= in_data;
                    state  <= Y_L;
                end
                Y_L: if (accept) begin
                    rem    <= rem_dec;
                    height <= DIM_W'({dim_hi, in_data});
                    state  <= X_H;
                end
                X_H: if (accept) begin
                    rem    <= rem_dec;
                    dim_hi <= in_data;
                    state  <= X_L;
                end
                X_L: if (accept) begin
                    rem   <= rem_dec;
                    width <= DIM_W'({dim_hi, in_data});
                    state <= NF;
                end
                NF: if (accept) begin
                    rem   <= rem_dec;
                    nf    <= in_data;
                    ncomp <= (in_data > 8'd7) ? 3'd7 : in_data[2:0];
                    if (nf_bad) err[1] <= 1'b1;
                    if (len_bad) err[0] <= 1'b1;
                    // Malformed header: drain what Lf says is left so the stream stays aligned.
                    if (nf_bad || len_bad) begin
                        state <= (rem_dec == 16'd0) ? CALC : SKIP;
                    end else begin
                        state <= C_ID;
                    end
                end
                C_ID: if (accept) begin
                    rem              <= rem_dec;
                    comp_id[k*8 +: 8] <= in_data;
                    state            <= C_HV;
                end
                C_HV: if (accept) begin
                    rem               <= rem_dec;
                    comp_h[k*3 +: 3]  <= in_data[6:4];
                    comp_v[k*3 +: 3]  <= in_data[2:0];
                    if (in_data[6:4] > hmax) hmax <= in_data[6:4];
                    if (in_data[2:0] > vmax) vmax <= in_data[2:0];
                    if (hv_bad) err[3] <= 1'b1;
                    state <= C_TQ;
                end
                C_TQ: if (accept) begin
                    rem              <= rem_dec;
                    comp_tq[k*2 +: 2] <= in_data[1:0];
                    if (in_data > 8'd3) err[4] <= 1'b1;
                    if ({5'd0, k} == nf - 8'd1) begin
                        state <= CALC;
                    end else begin
                        k     <= k + 3'd1;
                        state <= C_ID;
                    end
                end
                SKIP: if (accept) begin
                    rem <= rem_dec;
                    if (rem_dec == 16'd0) state <= CALC;
                end
                CALC: begin
                    err      <= err_calc;
                    fmt      <= fmt_calc;
                    mcu_cols <= mcu_ok ? cols_wide[DIM_W-1:0] : '0;
                    mcu_rows <= mcu_ok ? rows_wide[DIM_W-1:0] : '0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_sof_parser.sv
// Randomised and directed bench for jpeg_sof_parser; expectations come from a header-level
// model that interprets the whole byte array at once.
module tb_jpeg_sof_parser;

    localparam int MAX_COMP = 4;
    localparam int DIM_W    = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  busy;
    logic                  done;
    logic [5:0]            err;
    logic [DIM_W-1:0]      width;
    logic [DIM_W-1:0]      height;
    logic [2:0]            ncomp;
    logic [8*MAX_COMP-1:0] comp_id;
    logic [3*MAX_COMP-1:0] comp_h;
    logic [3*MAX_COMP-1:0] comp_v;
    logic [2*MAX_COMP-1:0] comp_tq;
    logic [2:0]            hmax;
    logic [2:0]            vmax;
    logic [1:0]            fmt;
    logic [DIM_W-1:0]      mcu_cols;
    logic [DIM_W-1:0]      mcu_rows;

    jpeg_sof_parser #(.MAX_COMP(MAX_COMP), .DIM_W(DIM_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .done(done), .err(err), .width(width),
        .height(height), .ncomp(ncomp), .comp_id(comp_id), .comp_h(comp_h),
        .comp_v(comp_v), .comp_tq(comp_tq), .hmax(hmax), .vmax(vmax), .fmt(fmt),
        .mcu_cols(mcu_cols), .mcu_rows(mcu_rows)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int done_pulses = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_pulses <= done_pulses + 1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] stream[$];

    // Expected results
    logic [5:0]  e_err;
    int          e_w, e_h, e_nc, e_hmax, e_vmax, e_fmt, e_cols, e_rows, e_consumed;
    logic [31:0] e_id;
    logic [11:0] e_hp, e_vp;
    logic [7:0]  e_tq;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit bad_sf(input int f);
        return (f == 0) || (f == 3) || (f > 4);
    endfunction

    // Interprets the header in the stream as a whole.
    task automatic model();
        int lf, nf, hs[4], vs[4], d;
        e_err = '0; e_w = 0; e_h = 0; e_nc = 0; e_hmax = 0; e_vmax = 0;
        e_fmt = 0; e_cols = 0; e_rows = 0; e_id = '0; e_hp = '0; e_vp = '0; e_tq = '0;
        lf = int'(stream[0]) * 256 + int'(stream[1]);
        if (lf < 8) begin
            e_err = 6'b100001;
            e_consumed = 2;
            return;
        end
        e_consumed = lf;
        if (stream[2] != 8'd8) e_err[2] = 1'b1;
        e_h  = int'(stream[3]) * 256 + int'(stream[4]);
        e_w  = int'(stream[5]) * 256 + int'(stream[6]);
        nf   = int'(stream[7]);
        e_nc = (nf > 7) ? 7 : nf;
        if (nf == 0 || nf > MAX_COMP) e_err[1] = 1'b1;
        if (lf != 8 + 3 * nf) e_err[0] = 1'b1;
        if (e_err[1:0] == 2'b00) begin
            for (int c = 0; c < nf; c++) begin
                hs[c] = int'(stream[9 + 3*c]) / 16;
                vs[c] = int'(stream[9 + 3*c]) % 16;
                if (bad_sf(hs[c]) || bad_sf(vs[c])) e_err[3] = 1'b1;
                hs[c] = hs[c] % 8;
                vs[c] = vs[c] % 8;
                e_id[8*c +: 8] = stream[8 + 3*c];
                e_hp[3*c +: 3] = 3'(hs[c]);
                e_vp[3*c +: 3] = 3'(vs[c]);
                e_tq[2*c +: 2] = stream[10 + 3*c][1:0];
                if (stream[10 + 3*c] > 8'd3) e_err[4] = 1'b1;
                if (hs[c] > e_hmax) e_hmax = hs[c];
                if (vs[c] > e_vmax) e_vmax = vs[c];
            end
        end
        if (e_w == 0 || e_h == 0) e_err[5] = 1'b1;
        if (e_err[1:0] == 2'b00) begin
            if (!e_err[3]) begin
                d = 8 * e_hmax;
                e_cols = (e_w + d - 1) / d;
                d = 8 * e_vmax;
                e_rows = (e_h + d - 1) / d;
            end
            if (nf == 1) e_fmt = 0;
            else if (nf == 3 && hs[1] == 1 && vs[1] == 1 && hs[2] == 1 && vs[2] == 1) begin
                if      (hs[0] == 1 && vs[0] == 1) e_fmt = 1;
                else if (hs[0] == 2 && vs[0] == 1) e_fmt = 2;
                else if (hs[0] == 2 && vs[0] == 2) e_fmt = 3;
                else e_err[3] = 1'b1;
            end else e_err[3] = 1'b1;
        end
    endtask

    task automatic build_frame(input int nf, input int w, input int h, input int prec,
                               input int luma_hv, input int tq_max);
        int lf;
        lf = 8 + 3 * nf;
        stream.delete();
        stream.push_back(8'(lf >> 8));  stream.push_back(8'(lf));
        stream.push_back(8'(prec));
        stream.push_back(8'(h >> 8));   stream.push_back(8'(h));
        stream.push_back(8'(w >> 8));   stream.push_back(8'(w));
        stream.push_back(8'(nf));
        for (int c = 0; c < nf; c++) begin
            stream.push_back(8'($urandom_range(255)));
            stream.push_back(8'((c == 0) ? luma_hv : 'h11));
            stream.push_back(8'($urandom_range(tq_max)));
        end
    endtask

    // Drives the stream (filler 0xAA past its end), then checks timing, consumption and outputs.
    task automatic run_frame(input string name, input int gap, input bit poke);
        int idx, last_acc, done_cyc, pulses0;
        bit done_seen;
        model();
        pulses0 = done_pulses;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({name, "_busy"}, 64'(busy), 64'd1);
        idx = 0; last_acc = -100; done_cyc = -1; done_seen = 1'b0;
        for (int n = 0; n < 3000 && !done_seen; n++) begin
            if (done === 1'b1) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                in_valid  = 1'b0;
            end else begin
                start    = poke && (n == 6);
                in_valid = ($urandom_range(99) >= gap);
                in_data  = (idx < stream.size()) ? stream[idx] : 8'hAA;
                if (in_valid && in_ready) begin
                    idx++;
                    last_acc = cyc;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk({name, "_done_seen"}, 64'(done_seen), 64'd1);
        chk({name, "_latency"},   64'(done_cyc - last_acc), 64'd2);
        chk({name, "_consumed"},  64'(idx), 64'(e_consumed));
        chk({name, "_err"},       64'(err), 64'(e_err));
        chk({name, "_busy_done"}, 64'(busy), 64'd0);
        chk({name, "_width"},     64'(width), 64'(e_w));
        chk({name, "_height"},    64'(height), 64'(e_h));
        chk({name, "_ncomp"},     64'(ncomp), 64'(e_nc));
        chk({name, "_comp_id"},   64'(comp_id), 64'(e_id));
        chk({name, "_comp_h"},    64'(comp_h), 64'(e_hp));
        chk({name, "_comp_v"},    64'(comp_v), 64'(e_vp));
        chk({name, "_comp_tq"},   64'(comp_tq), 64'(e_tq));
        chk({name, "_hmax"},      64'(hmax), 64'(e_hmax));
        chk({name, "_vmax"},      64'(vmax), 64'(e_vmax));
        chk({name, "_mcu_cols"},  64'(mcu_cols), 64'(e_cols));
        chk({name, "_mcu_rows"},  64'(mcu_rows), 64'(e_rows));
        if (e_err == 6'd0) chk({name, "_fmt"}, 64'(fmt), 64'(e_fmt));
        in_valid = 1'b1;
        in_data  = 8'hAA;
        @(negedge clk);
        chk({name, "_done_single"}, 64'(done), 64'd0);
        chk({name, "_ready_after"}, 64'(in_ready), 64'd0);
        chk({name, "_pulses"},      64'(done_pulses - pulses0), 64'd1);
        in_valid = 1'b0;
        $display("frame %s bytes=%0d err=%b %0dx%0d nf=%0d fmt=%0d mcu=%0dx%0d",
                 name, idx, err, width, height, ncomp, fmt, mcu_cols, mcu_rows);
    endtask

    initial begin
        int kind, luma, w, h;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_busy",  64'(busy), 64'd0);
        chk("reset_ready", 64'(in_ready), 64'd0);
        chk("reset_err",   64'(err), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        stream = '{8'h00, 8'h11, 8'h08, 8'h01, 8'hE0, 8'h02, 8'h80, 8'h03,
                   8'h01, 8'h22, 8'h00, 8'h02, 8'h11, 8'h01, 8'h03, 8'h11, 8'h01};
        run_frame("yuv420", 0, 1'b0);
        chk("yuv420_cols_const", 64'(mcu_cols), 64'd40);
        chk("yuv420_rows_const", 64'(mcu_rows), 64'd30);
        chk("yuv420_fmt_const",  64'(fmt), 64'd3);
        chk("yuv420_tq_const",   64'(comp_tq), 64'h14);

        stream = '{8'h00, 8'h11, 8'h08, 8'h00, 8'h4B, 8'h00, 8'h64, 8'h03,
                   8'h01, 8'h11, 8'h00, 8'h02, 8'h11, 8'h01, 8'h03, 8'h11, 8'h01};
        run_frame("yuv444_gaps", 40, 1'b1);
        chk("yuv444_cols_const", 64'(mcu_cols), 64'd13);
        chk("yuv444_rows_const", 64'(mcu_rows), 64'd10);

        stream = '{8'h00, 8'h0B, 8'h08, 8'h00, 8'h11, 8'h00, 8'h21, 8'h01, 8'h01, 8'h11, 8'h00};
        run_frame("gray", 10, 1'b0);
        chk("gray_cols_const", 64'(mcu_cols), 64'd5);
        chk("gray_rows_const", 64'(mcu_rows), 64'd3);

        stream = '{8'h00, 8'h12, 8'h08, 8'h00, 8'h10, 8'h00, 8'h10, 8'h03};
        for (int i = 0; i < 10; i++) stream.push_back(8'($urandom_range(255)));
        run_frame("len_mismatch", 20, 1'b0);

        stream = '{8'h00, 8'h17, 8'h08, 8'h00, 8'h10, 8'h00, 8'h10, 8'h05};
        for (int i = 0; i < 15; i++) stream.push_back(8'($urandom_range(255)));
        run_frame("nf_too_big", 0, 1'b0);
        chk("nf_too_big_err1", 64'(err[1]), 64'd1);

        stream = '{8'h00, 8'h05, 8'h08, 8'h00};
        run_frame("lf_short", 0, 1'b0);

        build_frame(3, 64, 64, 8, 'h31, 3);
        run_frame("hv31", 0, 1'b0);
        chk("hv31_err3", 64'(err[3]), 64'd1);

        // Reset in the middle of the component loop, then a clean re-parse.
        stream = '{8'h00, 8'h11, 8'h08, 8'h01, 8'hE0, 8'h02, 8'h80, 8'h03,
                   8'h07, 8'h44, 8'h03, 8'h02, 8'h11, 8'h01, 8'h03, 8'h11, 8'h01};
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = stream[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("midrst_busy",    64'(busy), 64'd0);
        chk("midrst_ready",   64'(in_ready), 64'd0);
        chk("midrst_err",     64'(err), 64'd0);
        chk("midrst_width",   64'(width), 64'd0);
        chk("midrst_comp_id", 64'(comp_id), 64'd0);
        chk("midrst_comp_h",  64'(comp_h), 64'd0);
        chk("midrst_hmax",    64'(hmax), 64'd0);
        chk("midrst_ncomp",   64'(ncomp), 64'd0);
        stream = '{8'h00, 8'h11, 8'h08, 8'h01, 8'hE0, 8'h02, 8'h80, 8'h03,
                   8'h01, 8'h22, 8'h00, 8'h02, 8'h11, 8'h01, 8'h03, 8'h11, 8'h01};
        run_frame("after_rst", 0, 1'b0);

        for (int f = 0; f < 24; f++) begin
            kind = $urandom_range(3);
            case (kind)
                0:       luma = ($urandom_range(1) == 0) ? 'h11 : 'h22;
                1:       luma = 'h11;
                2:       luma = 'h21;
                default: luma = 'h22;
            endcase
            w = ($urandom_range(15) == 0) ? 0 : $urandom_range(1, 4000);
            h = ($urandom_range(15) == 0) ? 65535 : $urandom_range(1, 3000);
            build_frame((kind == 0) ? 1 : 3, w, h,
                        ($urandom_range(9) == 0) ? 12 : 8, luma,
                        ($urandom_range(7) == 0) ? 7 : 3);
            run_frame($sformatf("rand%0d", f), $urandom_range(50), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
